// File: rtl/apb4_slave_bridge_pkg.sv
// Shared types and helpers for the APB4-to-register-bus bridge.
package apb_bridge_pkg;

    localparam int unsigned BR_MAX_STRB = 32;
    localparam int unsigned BR_MAX_DATA = BR_MAX_STRB * 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } apb_br_state_e;

    // Expand byte strobes into per-bit write enables.
    function automatic logic [BR_MAX_DATA-1:0] strb2biten(input logic [BR_MAX_STRB-1:0] strb);
        logic [BR_MAX_DATA-1:0] biten;
        biten = '0;
        for (int i = 0; i < int'(BR_MAX_STRB); i++) begin
            biten[8*i +: 8] = {8{strb[i]}};
        end
        return biten;
    endfunction

endpackage

// File: rtl/apb4_slave_bridge_timeout.sv
// Wait-cycle counter for the bridge; expired_c flags the last permitted wait cycle.
module apb_br_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en && !expired_c) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    // count holds the number of wait cycles already spent before the current one
    assign expired_c = (count == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb4_slave_bridge.sv
// APB4 completer that issues single-cycle requests on the CSR register bus,
// with address/protection filtering and a bounded wait for the response.
module apb4_slave_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 11,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter bit          SECURE_ONLY    = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [DATA_WIDTH/8-1:0]   PSTRB,
    input  logic [2:0]                PPROT,
    output logic                      PREADY,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic                      PSLVERR,
    output logic                      bus_req,
    output logic                      bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0]     bus_addr,
    output logic [DATA_WIDTH-1:0]     bus_wr_data,
    output logic [DATA_WIDTH-1:0]     bus_wr_biten,
    output logic                      bus_req_stall_wr,
    output logic                      bus_req_stall_rd,
    input  logic                      bus_ready,
    input  logic                      bus_err,
    input  logic [DATA_WIDTH-1:0]     bus_rd_data
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    apb_br_state_e state_q, state_d;

    logic                  bus_req_d, is_wr_d, stall_wr_d, stall_rd_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d, biten_d, prdata_d;
    logic                  resp_q, resp_d, slverr_d;
    logic                  setup_c, addr_bad_c, prot_bad_c, expired_c;
    logic                  unused_prot;

    assign setup_c    = PSEL && !PENABLE;
    assign addr_bad_c = ((PADDR >> ADDR_WIDTH) != '0) ||
                        ((PADDR & APB_ADDR_WIDTH'(STRB_WIDTH - 1)) != '0);
    assign prot_bad_c = SECURE_ONLY && PPROT[1];
    assign unused_prot = ^{PPROT[2], PPROT[0]};

    apb_br_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q != WAIT),
        .en       (state_q == WAIT),
        .expired_c(expired_c)
    );

    // Next state and next registered output values.
    always_comb begin
        state_d   = state_q;
        bus_req_d = 1'b0;
        is_wr_d   = bus_req_is_wr;
        addr_d    = bus_addr;
        wdata_d   = bus_wr_data;
        biten_d   = bus_wr_biten;
        resp_d    = 1'b0;
        slverr_d  = 1'b0;
        prdata_d  = '0;

        unique case (state_q)
            IDLE: begin
                if (setup_c) begin
                    if (addr_bad_c || prot_bad_c) begin
                        state_d  = ERR;
                        resp_d   = 1'b1;
                        slverr_d = 1'b1;
                    end else begin
                        state_d   = REQ;
                        bus_req_d = 1'b1;
                        is_wr_d   = PWRITE;
                        addr_d    = PADDR[ADDR_WIDTH-1:0];
                        wdata_d   = PWRITE ? PWDATA : '0;
                        biten_d   = PWRITE ? DATA_WIDTH'(strb2biten(BR_MAX_STRB'(PSTRB))) : '0;
                    end
                end
            end
            REQ, WAIT: begin
                if (bus_ready) begin
                    state_d  = RESP;
                    resp_d   = 1'b1;
                    slverr_d = bus_err;
                    prdata_d = (bus_req_is_wr || bus_err) ? '0 : bus_rd_data;
                end else if (state_q == WAIT && expired_c) begin
                    state_d  = ERR;
                    resp_d   = 1'b1;
                    slverr_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        stall_wr_d = (state_d == REQ || state_d == WAIT) && is_wr_d;
        stall_rd_d = (state_d == REQ || state_d == WAIT) && !is_wr_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            bus_req          <= 1'b0;
            bus_req_is_wr    <= 1'b0;
            bus_addr         <= '0;
            bus_wr_data      <= '0;
            bus_wr_biten     <= '0;
            bus_req_stall_wr <= 1'b0;
            bus_req_stall_rd <= 1'b0;
            resp_q           <= 1'b0;
            PSLVERR          <= 1'b0;
            PRDATA           <= '0;
        end else begin
            state_q          <= state_d;
            bus_req          <= bus_req_d;
            bus_req_is_wr    <= is_wr_d;
            bus_addr         <= addr_d;
            bus_wr_data      <= wdata_d;
            bus_wr_biten     <= biten_d;
            bus_req_stall_wr <= stall_wr_d;
            bus_req_stall_rd <= stall_rd_d;
            resp_q           <= resp_d;
            PSLVERR          <= slverr_d;
            PRDATA           <= prdata_d;
        end
    end

    // A requester that abandoned the transfer gets no completion strobe.
    assign PREADY = resp_q && PSEL;

endmodule

// File: tb/tb_apb4_slave_bridge.sv
// Self-checking bench for apb4_slave_bridge: directed scenarios plus randomized
// transfers scored against a transaction-level model of the bridge.
module tb_apb4_slave_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PREADY, PSLVERR;
    logic [31:0] PRDATA;
    logic        bus_req, bus_req_is_wr, bus_req_stall_wr, bus_req_stall_rd;
    logic [10:0] bus_addr;
    logic [31:0] bus_wr_data, bus_wr_biten;
    logic        bus_ready, bus_err;
    logic [31:0] bus_rd_data;

    always #5 clk = ~clk;

    apb4_slave_bridge #(
        .DATA_WIDTH(32), .ADDR_WIDTH(11), .APB_ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(TMO), .SECURE_ONLY(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
        .bus_req_stall_wr(bus_req_stall_wr), .bus_req_stall_rd(bus_req_stall_rd),
        .bus_ready(bus_ready), .bus_err(bus_err), .bus_rd_data(bus_rd_data)
    );

    int checks = 0;
    int errors = 0;

    // Observations from the last transfer
    int          obs_nreq, obs_lat, obs_stall_wr, obs_stall_rd;
    logic        obs_err, obs_iswr, obs_unstable, obs_early;
    logic [31:0] obs_rdata, obs_wdata, obs_biten;
    logic [10:0] obs_addr;

    // Model predictions
    int          exp_nreq, exp_lat, exp_stall_wr, exp_stall_rd;
    logic        exp_err;
    logic [31:0] exp_rdata, exp_wdata, exp_biten;
    logic [10:0] exp_addr;

    function automatic logic [31:0] expand_strb(input logic [3:0] s);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++) if (s[i]) r = r | (32'hFF << (8 * i));
        return r;
    endfunction

    // Transaction-level expectation: filter, then latency = 2 + wait cycles, capped by the timeout.
    task automatic predict(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot, input int delay,
                           input logic rerr, input logic [31:0] rdata);
        logic bad, timed_out;
        bad = ((addr >> 11) != 0) || (addr % 4 != 0) || prot[1];
        timed_out = (delay < 0) || (delay > TMO);
        exp_addr = addr[10:0];
        exp_wdata = wr ? wdata : 32'h0;
        exp_biten = wr ? expand_strb(strb) : 32'h0;
        if (bad) begin
            exp_nreq = 0; exp_lat = 1; exp_err = 1'b1; exp_rdata = 32'h0;
            exp_stall_wr = 0; exp_stall_rd = 0;
        end else begin
            exp_nreq = 1;
            exp_lat = timed_out ? 2 + TMO : 2 + delay;
            exp_err = timed_out ? 1'b1 : rerr;
            exp_rdata = (!timed_out && !wr && !rerr) ? rdata : 32'h0;
            exp_stall_wr = wr ? exp_lat - 1 : 0;
            exp_stall_rd = wr ? 0 : exp_lat - 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // One APB transfer; bus_ready pulses in access cycle delay+1 (delay<0: never).
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int delay,
                        input logic rerr, input logic [31:0] rdata, input int drop_at);
        int req_at = 0;
        obs_nreq = 0; obs_lat = 0; obs_stall_wr = 0; obs_stall_rd = 0;
        obs_err = 1'b0; obs_rdata = 32'h0; obs_unstable = 1'b0; obs_early = 1'b0;
        obs_addr = '0; obs_wdata = 32'h0; obs_biten = 32'h0; obs_iswr = 1'b0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
        PWDATA = wdata; PSTRB = strb; PPROT = prot;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (drop_at != 0 && cyc == drop_at) begin PSEL = 1'b0; PENABLE = 1'b0; end
            bus_ready   = (delay >= 0) && (cyc == delay + 1);
            bus_err     = bus_ready ? rerr : 1'($urandom);
            bus_rd_data = bus_ready ? rdata : $urandom;
            @(negedge clk);
            if (bus_req) begin
                obs_nreq++;
                if (req_at == 0) begin
                    req_at = cyc; obs_addr = bus_addr; obs_wdata = bus_wr_data;
                    obs_biten = bus_wr_biten; obs_iswr = bus_req_is_wr;
                end
            end else if (req_at != 0 && obs_lat == 0) begin
                if (bus_addr !== obs_addr || bus_wr_data !== obs_wdata ||
                    bus_wr_biten !== obs_biten || bus_req_is_wr !== obs_iswr)
                    obs_unstable = 1'b1;
            end
            if (bus_req_stall_wr) obs_stall_wr++;
            if (bus_req_stall_rd) obs_stall_rd++;
            if (PSEL && !PREADY && (PSLVERR || PRDATA != 32'h0)) obs_early = 1'b1;
            if (PREADY) begin obs_lat = cyc; obs_err = PSLVERR; obs_rdata = PRDATA; end
            @(posedge clk); #1;
            if (obs_lat != 0) break;
        end
        PSEL = 1'b0; PENABLE = 1'b0; bus_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        PSTRB = 0; PPROT = 0; bus_ready = 0; bus_err = 0; bus_rd_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({PREADY, PSLVERR, PRDATA, bus_req, bus_req_is_wr, bus_addr, bus_wr_data,
             bus_wr_biten, bus_req_stall_wr, bus_req_stall_rd} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b addr=%h biten=%h pready=%b pslverr=%b prdata=%h exp all 0",
                     bus_req, bus_addr, bus_wr_biten, PREADY, PSLVERR, PRDATA);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_write_basic;
        xfer(1'b1, 32'h010, 32'hDEADBEEF, 4'b0101, 3'b000, 0, 1'b0, 32'h0, 0);
        checks++; if (obs_nreq !== 1) begin errors++; $display("FAIL wr_nreq got %0d exp 1", obs_nreq); end
        checks++; if (obs_addr !== 11'h010) begin errors++; $display("FAIL wr_addr got %h exp 010", obs_addr); end
        checks++; if (obs_biten !== 32'h00FF00FF) begin errors++; $display("FAIL wr_biten got %h exp 00ff00ff", obs_biten); end
        checks++; if (obs_wdata !== 32'hDEADBEEF || obs_iswr !== 1'b1) begin errors++; $display("FAIL wr_data got %h/%b exp deadbeef/1", obs_wdata, obs_iswr); end
        checks++; if (obs_lat !== 2) begin errors++; $display("FAIL wr_latency got %0d exp 2", obs_lat); end
        checks++; if (obs_err !== 1'b0 || obs_rdata !== 32'h0) begin errors++; $display("FAIL wr_resp got err=%b rdata=%h exp 0/0", obs_err, obs_rdata); end
        checks++; if (obs_stall_wr !== 1 || obs_stall_rd !== 0) begin errors++; $display("FAIL wr_stall got wr=%0d rd=%0d exp 1/0", obs_stall_wr, obs_stall_rd); end
    endtask

    task automatic test_read_wait;
        xfer(1'b0, 32'h020, $urandom, 4'hF, 3'b000, 3, 1'b0, 32'h12345678, 0);
        checks++; if (obs_lat !== 5) begin errors++; $display("FAIL rd_latency got %0d exp 5", obs_lat); end
        checks++; if (obs_rdata !== 32'h12345678 || obs_err !== 1'b0) begin errors++; $display("FAIL rd_data got %h err=%b exp 12345678/0", obs_rdata, obs_err); end
        checks++; if (obs_unstable !== 1'b0 || obs_addr !== 11'h020) begin errors++; $display("FAIL rd_addr_stable got addr=%h unstable=%b exp 020/0", obs_addr, obs_unstable); end
        checks++; if (obs_stall_rd !== 4 || obs_stall_wr !== 0) begin errors++; $display("FAIL rd_stall got rd=%0d wr=%0d exp 4/0", obs_stall_rd, obs_stall_wr); end
        checks++; if (obs_biten !== 32'h0 || obs_wdata !== 32'h0) begin errors++; $display("FAIL rd_wr_fields got biten=%h wdata=%h exp 0/0", obs_biten, obs_wdata); end
    endtask

    task automatic test_bad_addr;
        logic [31:0] bad_addrs [4] = '{32'h0000_0800, 32'h0000_0013, 32'h0000_0012, 32'h8000_0010};
        for (int i = 0; i < 4; i++) begin
            xfer(1'($urandom), bad_addrs[i], $urandom, 4'hF, 3'b000, 0, 1'b0, 32'hFFFF_FFFF, 0);
            checks++;
            if (obs_nreq !== 0 || obs_lat !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
                errors++;
                $display("FAIL bad_addr %h got nreq=%0d lat=%0d err=%b rdata=%h exp 0/1/1/0",
                         bad_addrs[i], obs_nreq, obs_lat, obs_err, obs_rdata);
            end
        end
    endtask

    task automatic test_timeout;
        xfer(1'b0, 32'h100, 32'h0, 4'h0, 3'b000, -1, 1'b0, 32'h0, 0);
        checks++; if (obs_lat !== 2 + TMO || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin errors++; $display("FAIL tmo_never got lat=%0d err=%b rdata=%h exp %0d/1/0", obs_lat, obs_err, obs_rdata, 2 + TMO); end
        checks++; if (obs_stall_rd !== 1 + TMO) begin errors++; $display("FAIL tmo_stall got %0d exp %0d", obs_stall_rd, 1 + TMO); end
        xfer(1'b0, 32'h104, 32'h0, 4'h0, 3'b000, TMO, 1'b0, 32'hA5A5_0001, 0);
        checks++; if (obs_lat !== 2 + TMO || obs_err !== 1'b0 || obs_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL tmo_last_ok got lat=%0d err=%b rdata=%h exp %0d/0/a5a50001", obs_lat, obs_err, obs_rdata, 2 + TMO); end
        xfer(1'b1, 32'h108, 32'h1, 4'h1, 3'b000, TMO + 1, 1'b0, 32'h0, 0);
        checks++; if (obs_lat !== 2 + TMO || obs_err !== 1'b1) begin errors++; $display("FAIL tmo_late got lat=%0d err=%b exp %0d/1", obs_lat, obs_err, 2 + TMO); end
    endtask

    task automatic test_secure;
        xfer(1'b1, 32'h040, 32'h11, 4'hF, 3'b010, 0, 1'b0, 32'h0, 0);
        checks++; if (obs_nreq !== 0 || obs_lat !== 1 || obs_err !== 1'b1) begin errors++; $display("FAIL sec_reject got nreq=%0d lat=%0d err=%b exp 0/1/1", obs_nreq, obs_lat, obs_err); end
        xfer(1'b1, 32'h040, 32'h11, 4'hF, 3'b000, 0, 1'b0, 32'h0, 0);
        checks++; if (obs_nreq !== 1 || obs_lat !== 2 || obs_err !== 1'b0) begin errors++; $display("FAIL sec_accept got nreq=%0d lat=%0d err=%b exp 1/2/0", obs_nreq, obs_lat, obs_err); end
        xfer(1'b0, 32'h044, 32'h0, 4'h0, 3'b101, 1, 1'b0, 32'h0BAD_F00D, 0);
        checks++; if (obs_nreq !== 1 || obs_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL sec_prot101 got nreq=%0d rdata=%h exp 1/0badf00d", obs_nreq, obs_rdata); end
    endtask

    task automatic test_reset_mid;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h40; PPROT = 3'b000; PSTRB = 4'h0;
        bus_ready = 1'b0;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        idle(3);
        @(negedge clk);
        checks++; if (bus_req_stall_rd !== 1'b1) begin errors++; $display("FAIL mid_stall_rd got %b exp 1", bus_req_stall_rd); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({PREADY, PSLVERR, PRDATA, bus_req, bus_req_is_wr, bus_addr, bus_wr_data,
             bus_wr_biten, bus_req_stall_wr, bus_req_stall_rd} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got addr=%h stall_rd=%b pready=%b exp all 0",
                     bus_addr, bus_req_stall_rd, PREADY);
        end
        @(posedge clk); #1;
        rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        idle(1);
        xfer(1'b1, 32'h044, 32'h7777_0000, 4'hF, 3'b000, 1, 1'b0, 32'h0, 0);
        checks++; if (obs_nreq !== 1 || obs_lat !== 3 || obs_err !== 1'b0 || obs_biten !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_reset_xfer got nreq=%0d lat=%0d err=%b biten=%h exp 1/3/0/ffffffff", obs_nreq, obs_lat, obs_err, obs_biten); end
    endtask

    task automatic test_psel_drop;
        xfer(1'b0, 32'h030, 32'h0, 4'h0, 3'b000, 2, 1'b0, 32'hCAFE_F00D, 2);
        checks++; if (obs_nreq !== 1 || obs_lat !== 0) begin errors++; $display("FAIL drop_discard got nreq=%0d lat=%0d exp 1/0", obs_nreq, obs_lat); end
        xfer(1'b0, 32'h034, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h5A5A_1234, 0);
        checks++; if (obs_lat !== 2 || obs_rdata !== 32'h5A5A_1234) begin errors++; $display("FAIL drop_recover got lat=%0d rdata=%h exp 2/5a5a1234", obs_lat, obs_rdata); end
    endtask

    task automatic test_back_to_back;
        xfer(1'b1, 32'h060, 32'h1, 4'b0011, 3'b000, 1, 1'b1, 32'h0, 0);
        checks++; if (obs_lat !== 3 || obs_err !== 1'b1 || obs_biten !== 32'h0000_FFFF) begin errors++; $display("FAIL b2b_wr got lat=%0d err=%b biten=%h exp 3/1/0000ffff", obs_lat, obs_err, obs_biten); end
        xfer(1'b0, 32'h064, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0102_0304, 0);
        checks++; if (obs_lat !== 2 || obs_rdata !== 32'h0102_0304) begin errors++; $display("FAIL b2b_rd got lat=%0d rdata=%h exp 2/01020304", obs_lat, obs_rdata); end
        xfer(1'b1, 32'h066, 32'h0, 4'hF, 3'b000, 0, 1'b0, 32'h0, 0);
        checks++; if (obs_nreq !== 0 || obs_lat !== 1 || obs_err !== 1'b1) begin errors++; $display("FAIL b2b_bad got nreq=%0d lat=%0d err=%b exp 0/1/1", obs_nreq, obs_lat, obs_err); end
        xfer(1'b1, 32'h068, 32'h9, 4'h0, 3'b000, 0, 1'b0, 32'h0, 0);
        checks++; if (obs_nreq !== 1 || obs_lat !== 2 || obs_biten !== 32'h0) begin errors++; $display("FAIL b2b_nostrb got nreq=%0d lat=%0d biten=%h exp 1/2/0", obs_nreq, obs_lat, obs_biten); end
    endtask

    task automatic test_random;
        logic        wr, rerr;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          delay, sel;
        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom); wdata = $urandom; rdata = $urandom; strb = 4'($urandom);
            rerr = ($urandom_range(0, 4) == 0);
            addr = {21'd0, 9'($urandom), 2'b00};
            sel = int'($urandom_range(0, 9));
            if (sel == 0) addr = $urandom;
            if (sel == 1) addr = addr + 32'($urandom_range(1, 3));
            prot = 3'($urandom);
            if ($urandom_range(0, 3) != 0) prot[1] = 1'b0;
            delay = int'($urandom_range(0, 11)) - 1;
            predict(wr, addr, wdata, strb, prot, delay, rerr, rdata);
            xfer(wr, addr, wdata, strb, prot, delay, rerr, rdata, 0);
            checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", n, obs_lat, exp_lat); end
            checks++; if (obs_err !== exp_err || obs_rdata !== exp_rdata) begin errors++; $display("FAIL rnd%0d_resp got err=%b rdata=%h exp %b/%h", n, obs_err, obs_rdata, exp_err, exp_rdata); end
            checks++; if (obs_nreq !== exp_nreq) begin errors++; $display("FAIL rnd%0d_nreq got %0d exp %0d", n, obs_nreq, exp_nreq); end
            checks++; if (obs_stall_wr !== exp_stall_wr || obs_stall_rd !== exp_stall_rd) begin errors++; $display("FAIL rnd%0d_stall got %0d/%0d exp %0d/%0d", n, obs_stall_wr, obs_stall_rd, exp_stall_wr, exp_stall_rd); end
            checks++; if (obs_early !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle_resp got early response exp none", n); end
            if (exp_nreq == 1) begin
                checks++;
                if (obs_addr !== exp_addr || obs_wdata !== exp_wdata || obs_biten !== exp_biten ||
                    obs_iswr !== wr || obs_unstable !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd%0d_req got addr=%h wd=%h be=%h wr=%b unst=%b exp %h/%h/%h/%b/0",
                             n, obs_addr, obs_wdata, obs_biten, obs_iswr, obs_unstable,
                             exp_addr, exp_wdata, exp_biten, wr);
                end
            end
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_bad_addr();
        test_timeout();
        test_secure();
        test_reset_mid();
        test_psel_drop();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
